clk_opt_bank: RTL

Parametrised multi-channel clock-option block for the BRAM/logic tiles. Each of NUM_CH clock inputs is passed, inverted, or forced low or high, according to a 2-bit mode per channel. Modes are loaded through the configuration chain into a shadow shift register. They are committed to the active register only after a length-checked (optionally parity-checked) load completes, so a partial or corrupt load never disturbs the running clocks.

---
 rtl/clk_opt_bank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/clk_opt_bank.sv
// clk_opt_bank: multi-channel clock-option block for BRAM/logic tiles.
//
// Each channel's clock is passed, inverted, forced low or forced high by a
// 2-bit mode. Modes arrive serially on the configuration chain into a shadow
// shift register. They are copied into the active register only after a load
// of exactly CHAIN_LEN bits completes, so a short, long or corrupt load never
// disturbs the running clocks.
//
// Optional feature macro: CLK_OPT_BANK_PARITY_EN
//   When defined, the chain carries one extra bit, the first one shifted.
//   It is even parity over all mode bits, and a load is committed only if
//   the XOR of every chain bit is zero.
//
// Mode encoding per channel: 00 pass, 01 invert, 10 force 0, 11 force 1.
// scan_mode = 1 bypasses every channel (O = I). The chain still loads.
//
// Chain handshake: config_enable acts as a strict per-edge shift strobe.
// Every prog_clock rising edge that samples config_enable = 1 moves exactly
// one bit from ccff_head into sr[0]. The first edge that samples
// config_enable = 0 after a run of shifts closes the load. The following
// edge (COMMIT) accepts or rejects the load.
module clk_opt_bank #(
  parameter int         NUM_CH     = 4,
  parameter logic [1:0] RESET_MODE = 2'b00
) (
  input  logic              prog_clock,
  input  logic              prog_reset_n,
  input  logic              scan_mode,
  input  logic              config_enable,
  input  logic              ccff_head,
  input  logic [NUM_CH-1:0] clk_opt_I,
  output logic [NUM_CH-1:0] clk_opt_O,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err
);

`ifdef CLK_OPT_BANK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int MODE_BITS = 2 * NUM_CH;
  localparam int CHAIN_LEN = MODE_BITS + PAR_BITS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

  // Count value of a complete load, and the saturation value marking "too long".
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MODE_BITS-1:0]   active_q, active_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   parity_ok;
  logic                   load_ok;

  // Parity check over the whole shadow chain; without the feature every load passes.
`ifdef CLK_OPT_BANK_PARITY_EN
  always_comb begin
    parity_ok = ~(^sr_q);
  end
`else
  always_comb begin
    parity_ok = 1'b1;
  end
`endif

  // A load is accepted only if exactly CHAIN_LEN bits were shifted and parity holds.
  always_comb begin
    load_ok = (cnt_q == CNT_FULL) && parity_ok;
  end

  // Next-state logic for the chain, load counter, FSM and active register.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;

    // The chain shifts on every enabled edge, whatever the FSM state.
    if (config_enable) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (config_enable) begin
          state_d   = ST_SHIFT;
          cnt_d     = CNT_ONE;
          cfg_err_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (config_enable) begin
          // Stop counting one past a full load so overlength loads stay detectable.
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if (load_ok) begin
          // Mode k sits in sr[2k+1:2k]; the parity bit (if any) sits above them.
          active_d    = sr_q[MODE_BITS-1:0];
          cfg_valid_d = 1'b1;
          cfg_err_d   = 1'b0;
        end else begin
          cfg_err_d   = 1'b1;
        end
        // A back-to-back load may start in the commit cycle; that edge is its first bit.
        if (config_enable) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All configuration state is held on prog_clock with asynchronous reset.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      active_q    <= {NUM_CH{RESET_MODE}};
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Per-channel clock conditioning: purely combinational, zero latency from I to O.
  always_comb begin
    clk_opt_O = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (scan_mode) begin
        clk_opt_O[k] = clk_opt_I[k];
      end else begin
        unique case (active_q[2*k +: 2])
          2'b00:   clk_opt_O[k] = clk_opt_I[k];
          2'b01:   clk_opt_O[k] = ~clk_opt_I[k];
          2'b10:   clk_opt_O[k] = 1'b0;
          default: clk_opt_O[k] = 1'b1;
        endcase
      end
    end
  end

  assign ccff_tail = sr_q[CHAIN_LEN-1];
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule
